// File: rtl/fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller that drives an external dual-port RAM with a one-cycle registered read.
// Define FIFO_CTRL_ERR_EN to add the sticky overflow/underflow flags and their err_clr input.
module fifo_ctrl #(
  parameter int DATA_WIDTH    = 2,
  parameter int ADDR_WIDTH    = 5,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_CTRL_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_d;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance looks only at registered flags, so a same-cycle pop never frees room for a push (and vice versa).
  always_comb begin
    wr_acc  = wr_req & ~full & ~rst;
    rd_acc  = rd_req & ~empty & ~rst;
    wptr_d  = wptr_q + PTR_W'(wr_acc);
    rptr_d  = rptr_q + PTR_W'(rd_acc);
    // The wrap bit makes the pointer difference span 0..DEPTH, which equals the +1/-1 occupancy.
    count_d = CNT_W'(PTR_W'(wptr_d - rptr_d));
  end

  always_comb begin
    ram_wr_en   = wr_acc;
    ram_wr_addr = ADDR_WIDTH'(wptr_q[IDX_W-1:0]);
    ram_wr_data = wr_data;
    ram_rd_en   = rd_acc;
    ram_rd_addr = ADDR_WIDTH'(rptr_q[IDX_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count        <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count        <= count_d;
      rd_valid     <= rd_acc;
      empty        <= (count_d == '0);
      full         <= (count_d == DEPTH_C);
      almost_empty <= (count_d <= AEMPTY_C);
      almost_full  <= (count_d >= AFULL_C);
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  // Sticky error flags: a new violation wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req & full)      overflow <= 1'b1;
      else if (err_clr)       overflow <= 1'b0;
      if (rd_req & empty)     underflow <= 1'b1;
      else if (err_clr)       underflow <= 1'b0;
    end
  end
`endif

endmodule
